// File: rtl/mips16_pkg.sv
// Shared MIPS16 definitions: datapath widths, opcode values and instruction field positions.
// Used by the decode stage and by the ALU/control blocks downstream.
package mips16_pkg;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 2;
  localparam int NREG   = 4;
  localparam int IMM_W  = 8;

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_AND  = 4'h2;
  localparam logic [3:0] OP_OR   = 4'h3;
  localparam logic [3:0] OP_SLT  = 4'h4;
  localparam logic [3:0] OP_ADDI = 4'h5;
  localparam logic [3:0] OP_LW   = 4'h6;
  localparam logic [3:0] OP_SW   = 4'h7;
  localparam logic [3:0] OP_BEQ  = 4'h8;
  localparam logic [3:0] OP_BNE  = 4'h9;
  localparam logic [3:0] OP_NOP  = 4'hF;

  localparam int OP_HI  = 15;
  localparam int OP_LO  = 12;
  localparam int RS_HI  = 11;
  localparam int RS_LO  = 10;
  localparam int RT_HI  = 9;
  localparam int RT_LO  = 8;
  localparam int RD_HI  = 7;
  localparam int RD_LO  = 6;
  localparam int IMM_HI = 7;
  localparam int IMM_LO = 0;

  // dest_sel encoding: R-type writes rd, immediate forms write rt
  localparam logic DEST_RD = 1'b0;
  localparam logic DEST_RT = 1'b1;

  function automatic logic [NREG-1:0] onehot(input logic [ADDR_W-1:0] a);
    onehot    = '0;
    onehot[a] = 1'b1;
  endfunction

endpackage

// File: rtl/id_decoder.sv
// Combinational opcode decoder: which source registers are read, whether and where a result
// is written, and the opcode passed on to EX (illegal opcodes collapse to OP_NOP).
module id_decoder
  import mips16_pkg::*;
(
  input  logic [3:0] op,
  output logic       uses_rs,
  output logic       uses_rt,
  output logic       has_dest,
  output logic       dest_sel,
  output logic [3:0] op_out
);

  always_comb begin
    uses_rs  = 1'b0;
    uses_rt  = 1'b0;
    has_dest = 1'b0;
    dest_sel = DEST_RD;
    op_out   = OP_NOP;
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT: begin
        uses_rs  = 1'b1;
        uses_rt  = 1'b1;
        has_dest = 1'b1;
        dest_sel = DEST_RD;
        op_out   = op;
      end
      OP_ADDI, OP_LW: begin
        uses_rs  = 1'b1;
        has_dest = 1'b1;
        dest_sel = DEST_RT;
        op_out   = op;
      end
      OP_SW, OP_BEQ, OP_BNE: begin
        uses_rs  = 1'b1;
        uses_rt  = 1'b1;
        op_out   = op;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/id_stage.sv
// Instruction-decode stage: drives regfile read addresses, tracks pending writes per register,
// stalls on RAW/WAW hazards, forwards same-cycle writeback data and holds the ID/EX register.
module id_stage
  import mips16_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              if_valid,
  input  logic [DATA_W-1:0] if_instr,
  output logic              if_ready,
  output logic [ADDR_W-1:0] RR1,
  output logic [ADDR_W-1:0] RR2,
  input  logic [DATA_W-1:0] RD1,
  input  logic [DATA_W-1:0] RD2,
  input  logic              wb_regwrite,
  input  logic [ADDR_W-1:0] wb_wr,
  input  logic [DATA_W-1:0] wb_wd,
  output logic              ex_valid,
  input  logic              ex_ready,
  output logic [3:0]        ex_op,
  output logic [DATA_W-1:0] ex_a,
  output logic [DATA_W-1:0] ex_b,
  output logic [DATA_W-1:0] ex_imm,
  output logic [ADDR_W-1:0] ex_wr,
  output logic              ex_regwrite
);

  // Handshake: a transfer happens on a posedge where valid and ready are both high; a producer
  // holding valid keeps its payload stable until that edge, and ready never depends on a future cycle.

  logic              uses_rs, uses_rt, has_dest, dest_sel;
  logic [3:0]        op_out;
  logic [ADDR_W-1:0] rd, dest;
  logic [NREG-1:0]   busy, clr, busy_eff;
  logic              stall, accept;
  logic [DATA_W-1:0] fwd_a, fwd_b, imm_ext;

  assign RR1 = if_instr[RS_HI:RS_LO];
  assign RR2 = if_instr[RT_HI:RT_LO];
  assign rd  = if_instr[RD_HI:RD_LO];

  id_decoder u_decoder (
    .op       (if_instr[OP_HI:OP_LO]),
    .uses_rs  (uses_rs),
    .uses_rt  (uses_rt),
    .has_dest (has_dest),
    .dest_sel (dest_sel),
    .op_out   (op_out)
  );

  always_comb begin
    dest     = (dest_sel == DEST_RT) ? RR2 : rd;
    // A write landing this cycle retires its pending bit before the hazard check.
    clr      = wb_regwrite ? onehot(wb_wr) : '0;
    busy_eff = busy & ~clr;
    stall    = if_valid & ((uses_rs  & busy_eff[RR1]) |
                           (uses_rt  & busy_eff[RR2]) |
                           (has_dest & busy_eff[dest]));
    if_ready = ~stall & (~ex_valid | ex_ready);
    accept   = if_valid & if_ready;
    fwd_a    = (uses_rs && wb_regwrite && (wb_wr == RR1)) ? wb_wd : RD1;
    fwd_b    = (uses_rt && wb_regwrite && (wb_wr == RR2)) ? wb_wd : RD2;
    imm_ext  = {{(DATA_W-IMM_W){if_instr[IMM_HI]}}, if_instr[IMM_HI:IMM_LO]};
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      busy        <= '0;
      ex_valid    <= 1'b0;
      ex_op       <= OP_NOP;
      ex_a        <= '0;
      ex_b        <= '0;
      ex_imm      <= '0;
      ex_wr       <= '0;
      ex_regwrite <= 1'b0;
    end else begin
      // Set after clear, so a register retired and re-claimed in one cycle stays busy.
      busy <= busy_eff | ((accept && has_dest) ? onehot(dest) : '0);
      if (accept) begin
        ex_valid    <= 1'b1;
        ex_op       <= op_out;
        ex_a        <= fwd_a;
        ex_b        <= fwd_b;
        ex_imm      <= imm_ext;
        ex_wr       <= has_dest ? dest : '0;
        ex_regwrite <= has_dest;
      end else if (ex_ready) begin
        ex_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_id_stage.sv
// Bench for id_stage: a bench-owned register file, a reference model of decode/hazard rules,
// an expected-output queue for the ID/EX register and a monitor that compares against it.
module tb_id_stage;
  import mips16_pkg::*;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        if_valid = 1'b0;
  logic [15:0] if_instr = '0;
  logic        if_ready;
  logic [1:0]  RR1, RR2;
  logic [15:0] RD1, RD2;
  logic        wb_regwrite = 1'b0;
  logic [1:0]  wb_wr = '0;
  logic [15:0] wb_wd = '0;
  logic        ex_valid;
  logic        ex_ready = 1'b0;
  logic [3:0]  ex_op;
  logic [15:0] ex_a, ex_b, ex_imm;
  logic [1:0]  ex_wr;
  logic        ex_regwrite;

  always #5 clock = ~clock;

  id_stage dut (
    .clock(clock), .reset(reset), .if_valid(if_valid), .if_instr(if_instr), .if_ready(if_ready),
    .RR1(RR1), .RR2(RR2), .RD1(RD1), .RD2(RD2),
    .wb_regwrite(wb_regwrite), .wb_wr(wb_wr), .wb_wd(wb_wd),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_op(ex_op), .ex_a(ex_a), .ex_b(ex_b),
    .ex_imm(ex_imm), .ex_wr(ex_wr), .ex_regwrite(ex_regwrite)
  );

  // Register file: combinational read, write on posedge
  logic [15:0] regs [4];
  always @(posedge clock) if (wb_regwrite) regs[wb_wr] <= wb_wd;
  assign RD1 = regs[RR1];
  assign RD2 = regs[RR2];

  int n_tests = 0;
  int n_fail  = 0;

  logic [54:0] exp_q [$];
  logic [1:0]  wb_pending [$];
  bit          m_busy [4];
  bit          m_exv;
  logic [1:0]  m_ex_wr;
  bit          m_ex_rw;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // One cycle: drive inputs after negedge, check combinational outputs and state, advance the model.
  task automatic step(input bit v, input logic [15:0] ins, input bit exr,
                      input bit wrw, input logic [1:0] wr, input logic [15:0] wd);
    bit urs, urt, hd, legal, stall, rdy, acc;
    bit eff [4];
    logic [1:0]  rs, rt, d;
    logic [3:0]  op, mb;
    logic [15:0] a, b, imm;
    @(negedge clock);
    if_valid = v; if_instr = ins; ex_ready = exr;
    wb_regwrite = wrw; wb_wr = wr; wb_wd = wd;
    #1;
    op = ins[15:12]; rs = ins[11:10]; rt = ins[9:8];
    legal = (op <= 4'd9);
    urs   = legal;
    urt   = (op <= 4'd4) || (op >= 4'd7 && op <= 4'd9);
    hd    = (op <= 4'd6);
    d     = (op <= 4'd4) ? ins[7:6] : rt;
    for (int r = 0; r < 4; r++) eff[r] = m_busy[r] && !(wrw && wr == r[1:0]);
    stall = v && ((urs && eff[rs]) || (urt && eff[rt]) || (hd && eff[d]));
    rdy   = !stall && (!m_exv || exr);
    for (int r = 0; r < 4; r++) mb[r] = m_busy[r];
    chk("if_ready", 64'(if_ready), 64'(rdy));
    chk("ex_valid", 64'(ex_valid), 64'(m_exv));
    chk("busy", 64'(dut.busy), 64'(mb));
    if (v) chk("read_addr", 64'({RR1, RR2}), 64'({rs, rt}));
    acc = v && rdy;
    if (m_exv && exr && m_ex_rw) wb_pending.push_back(m_ex_wr);
    if (acc) begin
      a   = (urs && wrw && wr == rs) ? wd : regs[rs];
      b   = (urt && wrw && wr == rt) ? wd : regs[rt];
      imm = 16'($signed(ins[7:0]));
      exp_q.push_back({legal ? op : OP_NOP, a, b, imm, hd ? d : 2'd0, hd});
      m_exv = 1'b1; m_ex_wr = hd ? d : 2'd0; m_ex_rw = hd;
    end else if (exr) begin
      m_exv = 1'b0;
    end
    for (int r = 0; r < 4; r++) m_busy[r] = eff[r];
    if (acc && hd) m_busy[d] = 1'b1;
  endtask

  task automatic model_reset();
    for (int r = 0; r < 4; r++) m_busy[r] = 1'b0;
    m_exv = 1'b0; m_ex_wr = '0; m_ex_rw = 1'b0;
    exp_q.delete();
    wb_pending.delete();
  endtask

  // Monitor: while ID/EX is valid it must equal the oldest expected entry; pop on transfer.
  initial begin
    forever begin
      @(negedge clock);
      #2;
      if (!reset && ex_valid) begin
        if (exp_q.size() == 0) begin
          chk("ex_unexpected", 64'(ex_valid), 64'(0));
        end else begin
          chk("ex_bundle", 64'({ex_op, ex_a, ex_b, ex_imm, ex_wr, ex_regwrite}), 64'(exp_q[0]));
          if (ex_ready) void'(exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    bit          v, exr, wrw;
    logic [15:0] ins, wd;
    logic [1:0]  wr;
    model_reset();
    repeat (2) @(negedge clock);
    reset = 1'b0;
    // Load registers: r0=0, r1=3, r2=4, r3=0
    step(0, 16'h0, 1, 1, 2'd0, 16'h0000);
    step(0, 16'h0, 1, 1, 2'd1, 16'h0003);
    step(0, 16'h0, 1, 1, 2'd2, 16'h0004);
    step(0, 16'h0, 1, 1, 2'd3, 16'h0000);

    // ADD r3 = r1 + r2
    step(1, 16'h06C0, 1, 0, 2'd0, 16'h0);
    // SUB r0 = r3 - r1: stalls on r3 until its writeback, which is forwarded
    step(1, 16'h1D00, 1, 0, 2'd0, 16'h0);
    step(1, 16'h1D00, 1, 0, 2'd0, 16'h0);
    step(1, 16'h1D00, 1, 1, 2'd3, 16'h0007);
    // ADDI r2 = r1 + (-1), then LW r2 stalls (WAW) until r2 retires
    step(1, 16'h56FF, 1, 0, 2'd0, 16'h0);
    step(1, 16'h6604, 1, 0, 2'd0, 16'h0);
    step(1, 16'h6604, 1, 0, 2'd0, 16'h0);
    step(1, 16'h6604, 1, 1, 2'd2, 16'h00AA);
    // Back-pressure: ID/EX held for three cycles, then drained
    step(0, 16'h0, 0, 0, 2'd0, 16'h0);
    step(0, 16'h0, 0, 0, 2'd0, 16'h0);
    step(0, 16'h0, 0, 0, 2'd0, 16'h0);
    step(0, 16'h0, 1, 0, 2'd0, 16'h0);
    step(0, 16'h0, 1, 0, 2'd0, 16'h0);
    // Illegal opcode becomes a NOP and leaves busy alone
    step(1, 16'hC000, 1, 0, 2'd0, 16'h0);
    step(0, 16'h0, 1, 1, 2'd0, 16'h1111);
    step(0, 16'h0, 1, 1, 2'd2, 16'h2222);
    // Claim r1, then retire and re-claim r1 in the same cycle
    step(1, 16'h0F40, 1, 0, 2'd0, 16'h0);
    step(1, 16'h0F40, 1, 1, 2'd1, 16'h5555);
    step(0, 16'h0, 1, 0, 2'd0, 16'h0);
    // Reset in the middle of a cycle with an instruction in flight
    step(1, 16'h0F40, 0, 1, 2'd1, 16'h6666);
    @(negedge clock);
    if_valid = 1'b0; ex_ready = 1'b0; wb_regwrite = 1'b0;
    #3;
    reset = 1'b1;
    #1;
    chk("rst_ex_valid", 64'(ex_valid), 64'(0));
    chk("rst_ex_op", 64'(ex_op), 64'(OP_NOP));
    chk("rst_ex_a_b_imm", 64'({ex_a, ex_b, ex_imm}), 64'(0));
    chk("rst_ex_wr_rw", 64'({ex_wr, ex_regwrite}), 64'(0));
    chk("rst_busy", 64'(dut.busy), 64'(0));
    model_reset();
    @(negedge clock);
    reset = 1'b0;
    step(0, 16'h0, 0, 0, 2'd0, 16'h0);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      v   = ($urandom_range(0, 3) != 0);
      ins = 16'($urandom);
      exr = ($urandom_range(0, 3) != 0);
      wrw = 1'b0; wr = '0; wd = 16'($urandom);
      if (wb_pending.size() > 0 && $urandom_range(0, 1) == 1) begin
        wrw = 1'b1; wr = wb_pending.pop_front();
      end else if ($urandom_range(0, 7) == 0) begin
        wrw = 1'b1; wr = 2'($urandom_range(0, 3));
      end
      step(v, ins, exr, wrw, wr, wd);
    end
    // Drain outstanding work
    for (int i = 0; i < 20; i++) begin
      wrw = 1'b0; wr = '0; wd = 16'($urandom);
      if (wb_pending.size() > 0) begin
        wrw = 1'b1; wr = wb_pending.pop_front();
      end
      step(0, 16'h0, 1, wrw, wr, wd);
    end
    @(negedge clock);
    #3;
    chk("drained", 64'(exp_q.size()), 64'(0));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
